// File: rtl/sixbitcalc_pkg.sv
// rtl/sixbitcalc_pkg.sv - shared widths and state encoding for the 6-bit calculator
//
// Purpose: common constants and the exponential sequencer state type.
// Ports:   none (package).
package sixbitcalc_pkg;

   localparam int WIDTH     = 6;
   localparam int MAX_TERMS = 7;
   localparam int PROD_W    = 2 * WIDTH;
   localparam int K_W       = $clog2(MAX_TERMS + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      ACC  = 3'd3,
      DONE = 3'd4
   } exp_state_t;

endpackage

// File: rtl/sixbitadd.sv
// rtl/sixbitadd.sv - 6-bit unsigned adder with carry out
//
// Purpose: plain 6-bit add used by the calculator datapaths.
// Ports:   a, b  - 6-bit addends
//          sum   - low 6 bits of a+b
//          cout  - carry out of bit 5
module sixbitadd
   import sixbitcalc_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sixbitexp_term.sv
// rtl/sixbitexp_term.sv - next series term (term*a)/k with overflow drop
//
// Purpose: combinational term update for the exponential sequencer.
// Ports:   term      - current 6-bit term
//          a         - latched 6-bit operand
//          k         - series index, always >= 1
//          next_term - (term*a)/k truncated, or 0 when the product exceeds 63
//          term_ovf  - product term*a exceeded 63
module sixbitexp_term
   import sixbitcalc_pkg::*;
(
   input  logic [WIDTH-1:0] term,
   input  logic [WIDTH-1:0] a,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] next_term,
   output logic             term_ovf
);

   logic [PROD_W-1:0] prod;

   assign prod     = {{WIDTH{1'b0}}, term} * {{WIDTH{1'b0}}, a};
   assign term_ovf = (prod > PROD_W'(63));

   // An overflowed product is dropped rather than saturated; once the term
   // is zero every later product stays zero on its own.
   assign next_term = term_ovf ? '0
                    : prod[WIDTH-1:0] / {{(WIDTH-K_W){1'b0}}, k};

endmodule

// File: rtl/sixbitexp_seq.sv
// rtl/sixbitexp_seq.sv - multi-cycle e^ain series sequencer
//
// Purpose: computes sum_{k=0..TERMS} ain^k/k! one operation per cycle
//          (MUL, DIV, ACC per term) on a shared term/accumulate path.
// Build option: SIXBITEXP_EARLY_EXIT_EN - finish as soon as a term becomes
//          zero; results are unchanged, only latency varies.
// Ports:   clk      - rising-edge clock
//          rst_n    - asynchronous active-low reset
//          start    - request, sampled only in IDLE
//          ain      - 6-bit operand, latched on accepted start
//          busy     - high while MUL/DIV/ACC are sequencing
//          done     - one-cycle completion pulse
//          out      - 6-bit result, held until the next accepted start
//          overflow - sticky error for the operation, held with out
module sixbitexp_seq
   import sixbitcalc_pkg::*;
#(
   parameter int TERMS = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             overflow
);

   exp_state_t       state, state_nxt;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] term;
   logic [K_W-1:0]   k;
   logic             ovf;

   logic [WIDTH-1:0] next_term;
   logic             term_ovf;
   logic [WIDTH-1:0] add_s;
   logic             add_c;
   logic             k_last;

   assign k_last = (k == K_W'(TERMS));

   sixbitexp_term u_term (
      .term      (term),
      .a         (a),
      .k         (k),
      .next_term (next_term),
      .term_ovf  (term_ovf)
   );

   sixbitadd u_add (
      .a    (sum),
      .b    (term),
      .sum  (add_s),
      .cout (add_c)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = MUL;
         MUL: begin
            busy      = 1'b1;
            state_nxt = DIV;
         end
         DIV: begin
            busy      = 1'b1;
            state_nxt = ACC;
`ifdef SIXBITEXP_EARLY_EXIT_EN
            if (next_term == '0) state_nxt = DONE;
`endif
         end
         ACC: begin
            busy      = 1'b1;
            state_nxt = k_last ? DONE : MUL;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a        <= '0;
         sum      <= '0;
         term     <= '0;
         k        <= '0;
         ovf      <= 1'b0;
         out      <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  a    <= ain;
                  sum  <= WIDTH'(1);
                  term <= WIDTH'(1);
                  k    <= K_W'(1);
                  ovf  <= 1'b0;
               end
            end
            // term, a and k are stable across MUL and DIV, so the product
            // check is recorded here and the divided term is taken in DIV.
            MUL: begin
               if (term_ovf) ovf <= 1'b1;
            end
            DIV: begin
               term <= next_term;
`ifdef SIXBITEXP_EARLY_EXIT_EN
               if (next_term == '0) begin
                  out      <= sum;
                  overflow <= ovf;
               end
`endif
            end
            ACC: begin
               sum <= add_s;
               if (add_c) ovf <= 1'b1;
               if (k_last) begin
                  out      <= add_s;
                  overflow <= ovf | add_c;
               end else begin
                  k <= k + K_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sixbitexp_seq.sv
// tb/tb_sixbitexp_seq.sv - scoreboard bench for sixbitexp_seq (TERMS=2 and TERMS=3)
module tb_sixbitexp_seq;

   typedef struct {
      logic [5:0] out;
      logic       ovf;
      int         lat;
   } exp_t;

   logic            clk;
   logic [1:0]      rst_n_v;
   logic [1:0]      start_v;
   logic [1:0][5:0] ain_v;
   logic [1:0]      busy_v;
   logic [1:0]      done_v;
   logic [1:0][5:0] out_v;
   logic [1:0]      ovf_v;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc;
   int   st[2];
   int   dcnt[2];
   int   bc[2];
   int   vectors;
   int   miscompares;

   sixbitexp_seq #(.TERMS(2)) u_t2 (
      .clk      (clk),
      .rst_n    (rst_n_v[0]),
      .start    (start_v[0]),
      .ain      (ain_v[0]),
      .busy     (busy_v[0]),
      .done     (done_v[0]),
      .out      (out_v[0]),
      .overflow (ovf_v[0])
   );

   sixbitexp_seq #(.TERMS(3)) u_t3 (
      .clk      (clk),
      .rst_n    (rst_n_v[1]),
      .start    (start_v[1]),
      .ain      (ain_v[1]),
      .busy     (busy_v[1]),
      .done     (done_v[1]),
      .out      (out_v[1]),
      .overflow (ovf_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [5:0] v, input int t);
      exp_t r;
      int   sum, term, p, s;
      sum   = 1;
      term  = 1;
      r.ovf = 1'b0;
      r.lat = 3 * t + 1;
      for (int k = 1; k <= t; k++) begin
         p = term * int'(v);
         if (p > 63) begin
            r.ovf = 1'b1;
            term  = 0;
         end else begin
            term = p / k;
         end
`ifdef SIXBITEXP_EARLY_EXIT_EN
         if (term == 0) begin
            r.lat = 3 * k;
            break;
         end
`endif
         s = sum + term;
         if (s > 63) r.ovf = 1'b1;
         sum = s % 64;
      end
      r.out = 6'(sum);
      return r;
   endfunction

   task automatic sample(input int w);
      exp_t  e;
      bit    empty;
      string p;
      p = $sformatf("t%0d_", w + 2);
      if (!rst_n_v[w]) begin
         bc[w] = 0;
      end else begin
         if (busy_v[w]) bc[w]++;
         if (done_v[w]) begin
            dcnt[w]++;
            empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
               chk({p, "unexpected_done"}, 1, 0);
            end else begin
               e = (w == 0) ? q0.pop_front() : q1.pop_front();
               chk({p, "out"},        out_v[w],     e.out);
               chk({p, "overflow"},   ovf_v[w],     e.ovf);
               chk({p, "latency"},    cyc - st[w],  e.lat);
               chk({p, "busy_count"}, bc[w],        e.lat - 1);
               chk({p, "busy_at_done"}, busy_v[w],  0);
            end
            bc[w] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      sample(0);
      sample(1);
   end

   task automatic op(input int w, input logic [5:0] v, input int dup_at);
      int d0;
      @(negedge clk);
      ain_v[w]   = v;
      start_v[w] = 1'b1;
      st[w]      = cyc;
      d0         = dcnt[w];
      if (w == 0) q0.push_back(model(v, 2));
      else        q1.push_back(model(v, 3));
      @(negedge clk);
      start_v[w] = 1'b0;
      ain_v[w]   = 6'($urandom);
      for (int i = 0; i < 60 && dcnt[w] == d0; i++) begin
         @(negedge clk);
         start_v[w] = (dup_at != 0) && (cyc - st[w] == dup_at);
      end
      start_v[w] = 1'b0;
      chk($sformatf("t%0d_done_seen_ain%0d", w + 2, v), dcnt[w] - d0, 1);
      repeat (5) @(negedge clk);
      chk($sformatf("t%0d_single_done_ain%0d", w + 2, v), dcnt[w] - d0, 1);
   endtask

   initial begin
      int s, d0;
      vectors     = 0;
      miscompares = 0;
      rst_n_v     = 2'b00;
      start_v     = 2'b00;
      ain_v       = '0;
      foreach (st[i])   st[i] = 0;
      foreach (dcnt[i]) dcnt[i] = 0;
      foreach (bc[i])   bc[i] = 0;

      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         chk("reset_out",      out_v[w],  0);
         chk("reset_overflow", ovf_v[w],  0);
         chk("reset_busy",     busy_v[w], 0);
         chk("reset_done",     done_v[w], 0);
      end
      rst_n_v = 2'b11;

      op(0, 6'd0,  0);
      op(0, 6'd10, 0);
      op(0, 6'd11, 0);
      op(0, 6'd63, 0);
      op(0, 6'd1,  0);
      op(0, 6'd7,  0);
      for (int i = 0; i < 5; i++) begin
         op(0, 6'($urandom_range(0, 63)), 0);
         op(1, 6'($urandom_range(0, 63)), 0);
      end
      op(1, 6'd2, 0);
      op(1, 6'd3, 4);

      // abandon a TERMS=3 computation in cycle 5
      @(negedge clk);
      ain_v[1]   = 6'd5;
      start_v[1] = 1'b1;
      s          = cyc;
      d0         = dcnt[1];
      @(negedge clk);
      start_v[1] = 1'b0;
      for (int i = 0; i < 20 && cyc - s < 5; i++) @(negedge clk);
      chk("t3_busy_before_reset", busy_v[1], 1);
      rst_n_v[1] = 1'b0;
      #1;
      chk("t3_reset_out",      out_v[1],  0);
      chk("t3_reset_overflow", ovf_v[1],  0);
      chk("t3_reset_busy",     busy_v[1], 0);
      chk("t3_reset_done",     done_v[1], 0);
      repeat (2) @(negedge clk);
      rst_n_v[1] = 1'b1;
      repeat (15) @(negedge clk);
      chk("t3_no_done_after_reset", dcnt[1] - d0, 0);

      op(1, 6'd1, 0);
      op(1, 6'd5, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
